// File: rtl/isp8_scratch_arb_pkg.sv
// Shared encodings for the isp8 scratchpad arbiter: FSM states, port IDs and arbitration modes.
package isp8_scratch_arb_pkg;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    CLEAR  = 3'd1,
    IDLE   = 3'd2,
    ACCESS = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int unsigned RR    = 0;
  localparam int unsigned FIXED = 1;

endpackage

// File: rtl/isp8_rr_pick.sv
// Two-way winner select for the scratchpad arbiter; purely combinational, no latency.
// Round-robin gives a tie to the port that was not served last; fixed mode always favours A.
module isp8_rr_pick
  import isp8_scratch_arb_pkg::*;
#(
  parameter int unsigned ARB_MODE = RR
) (
  input  logic a_req_i,
  input  logic b_req_i,
  input  logic last_gnt_i,
  output logic any_o,
  output logic win_o
);

  always_comb begin
    any_o = a_req_i | b_req_i;
    win_o = PORT_A;
    if (a_req_i && b_req_i) begin
      win_o = (ARB_MODE == FIXED) ? PORT_A : ~last_gnt_i;
    end else if (b_req_i) begin
      win_o = PORT_B;
    end
  end

endmodule

// File: rtl/isp8_scratch_arb.sv
// Serialises two masters onto the 32x8 scratchpad (async read, sync write); 3 cycles per access.
// Requests are held pending until acked, including during the post-reset zero-fill.
module isp8_scratch_arb
  import isp8_scratch_arb_pkg::*;
#(
  parameter int unsigned AW       = 5,
  parameter int unsigned DW       = 8,
  parameter int unsigned ARB_MODE = RR,
  parameter int unsigned CLEAR_EN = 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          a_req_i,
  input  logic          a_we_i,
  input  logic [AW-1:0] a_addr_i,
  input  logic [DW-1:0] a_wdata_i,
  output logic [DW-1:0] a_rdata_o,
  output logic          a_ack_o,
  input  logic          b_req_i,
  input  logic          b_we_i,
  input  logic [AW-1:0] b_addr_i,
  input  logic [DW-1:0] b_wdata_i,
  output logic [DW-1:0] b_rdata_o,
  output logic          b_ack_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_wdata_o,
  output logic          ram_we_o,
  input  logic [DW-1:0] ram_rdata_i,
  output logic          init_done_o,
  output logic          busy_o
);

  localparam logic [AW-1:0] CLR_LAST = '1;

  state_e        state_q;
  logic          gnt_q;
  logic          last_gnt_q;
  logic [AW-1:0] clr_cnt_q;
  logic          a_ack_q;
  logic          b_ack_q;
  logic [DW-1:0] a_rdata_q;
  logic [DW-1:0] b_rdata_q;
  logic          init_done_q;
  logic          req_any_d;
  logic          win_d;

  isp8_rr_pick #(
    .ARB_MODE (ARB_MODE)
  ) u_pick (
    .a_req_i    (a_req_i),
    .b_req_i    (b_req_i),
    .last_gnt_i (last_gnt_q),
    .any_o      (req_any_d),
    .win_o      (win_d)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= INIT;
      gnt_q       <= PORT_A;
      last_gnt_q  <= PORT_B;
      clr_cnt_q   <= '0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      // Acks are single-cycle: raised on leaving ACCESS, dropped on leaving DONE.
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      case (state_q)
        INIT: begin
          if (CLEAR_EN != 0) begin
            state_q <= CLEAR;
          end else begin
            state_q     <= IDLE;
            init_done_q <= 1'b1;
          end
        end
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == CLR_LAST) begin
            init_done_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        IDLE: begin
          if (req_any_d) begin
            gnt_q   <= win_d;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (gnt_q == PORT_A) begin
            a_ack_q <= 1'b1;
            if (!a_we_i) a_rdata_q <= ram_rdata_i;
          end else begin
            b_ack_q <= 1'b1;
            if (!b_we_i) b_rdata_q <= ram_rdata_i;
          end
          last_gnt_q <= gnt_q;
          state_q    <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= INIT;
        end
      endcase
    end
  end

  // RAM strobes depend only on registered state/grant/counter plus the granted port's stable bus.
  always_comb begin
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_we_o    = 1'b0;
    case (state_q)
      CLEAR: begin
        ram_addr_o = clr_cnt_q;
        ram_we_o   = 1'b1;
      end
      ACCESS: begin
        if (gnt_q == PORT_B) begin
          ram_addr_o  = b_addr_i;
          ram_wdata_o = b_wdata_i;
          ram_we_o    = b_we_i;
        end else begin
          ram_addr_o  = a_addr_i;
          ram_wdata_o = a_wdata_i;
          ram_we_o    = a_we_i;
        end
      end
      default: begin
      end
    endcase
  end

  assign a_ack_o     = a_ack_q;
  assign b_ack_o     = b_ack_q;
  assign a_rdata_o   = a_rdata_q;
  assign b_rdata_o   = b_rdata_q;
  assign init_done_o = init_done_q;
  assign busy_o      = (state_q != IDLE);

endmodule
